// File: rtl/mat_mul_pkg.sv
// Shared types and sizing helpers for the mat_mul scheduler.
package mat_mul_pkg;

    typedef enum logic {FLUSH, RUN} state_t;

    // Register depth of the mat_mul summation tree.
    function automatic int lat_f(input int n);
        return $clog2(n);
    endfunction

    function automatic int id_w_f(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from last+1,
// pointer advances only when enabled and a grant is issued.
module rr_arbiter
    import mat_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W = id_w_f(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    logic [ID_W-1:0] last;
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last) + k) % NUM_REQ);
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

    // Reset to the last index so requester 0 wins the first arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= ID_W'(NUM_REQ - 1);
        else if (found)
            last <= gnt_idx;
    end

endmodule

// File: rtl/mat_mul_sched.sv
// Shares one mat_mul datapath among NUM_REQ requesters, tracks IDs through the
// pipeline and returns results on one valid/ready channel. MAT_MUL_SCHED_PERF_EN adds perf counters.
module mat_mul_sched
    import mat_mul_pkg::*;
#(
    parameter int W_IN    = 8,
    parameter int W_OUT   = 32,
    parameter int N       = 2,
    parameter int NUM_REQ = 4,
    localparam int LAT  = lat_f(N),
    localparam int ID_W = id_w_f(NUM_REQ)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_REQ-1:0]                         req_valid,
    output logic [NUM_REQ-1:0]                         req_ready,
    input  logic [NUM_REQ-1:0][N-1:0][N-1:0][W_IN-1:0] req_matrix_1,
    input  logic [NUM_REQ-1:0][N-1:0][N-1:0][W_IN-1:0] req_matrix_2,
    output logic                                       resp_valid,
    input  logic                                       resp_ready,
    output logic [ID_W-1:0]                            resp_id,
    output logic [N-1:0][N-1:0][W_OUT-1:0]             resp_result,
    output logic                                       mm_cen,
    output logic                                       mm_valid_in,
    output logic [N-1:0][N-1:0][W_IN-1:0]              mm_matrix_1,
    output logic [N-1:0][N-1:0][W_IN-1:0]              mm_matrix_2,
    input  logic                                       mm_valid_out,
    input  logic [N-1:0][N-1:0][W_OUT-1:0]             mm_result,
    output logic                                       err
`ifdef MAT_MUL_SCHED_PERF_EN
    ,
    output logic [31:0]                                perf_ops,
    output logic [31:0]                                perf_stall,
    output logic [31:0]                                perf_idle
`endif
);

    localparam int CNT_W = id_w_f(LAT + 1);

    state_t             state;
    logic [CNT_W-1:0]   flush_cnt;
    logic               run;
    logic               adv;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               grant_vld;
    logic               tail_vld;
    logic [ID_W-1:0]    tail_id;

    assign run       = (state == RUN);
    assign adv       = !resp_valid || resp_ready;
    assign grant_vld = |gnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .en      (run && adv),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready   = gnt;
    assign mm_valid_in = grant_vld;
    assign mm_cen      = run ? adv : 1'b1;
    assign mm_matrix_1 = grant_vld ? req_matrix_1[gnt_idx] : '0;
    assign mm_matrix_2 = grant_vld ? req_matrix_2[gnt_idx] : '0;

    // FLUSH clocks LAT idle cycles through mat_mul, whose valid stages have no reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= (LAT == 0) ? RUN : FLUSH;
            flush_cnt <= '0;
        end else if (state == FLUSH) begin
            if (flush_cnt == CNT_W'(LAT - 1))
                state <= RUN;
            else
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    generate
        if (LAT > 0) begin : g_trk
            logic [LAT-1:0]           trk_vld;
            logic [LAT-1:0][ID_W-1:0] trk_id;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    trk_vld <= '0;
                    trk_id  <= '0;
                end else if (adv) begin
                    trk_vld[0] <= grant_vld;
                    trk_id[0]  <= gnt_idx;
                    for (int i = 1; i < LAT; i++) begin
                        trk_vld[i] <= trk_vld[i-1];
                        trk_id[i]  <= trk_id[i-1];
                    end
                end
            end

            assign tail_vld = trk_vld[LAT-1];
            assign tail_id  = trk_id[LAT-1];
        end else begin : g_no_trk
            assign tail_vld = grant_vld;
            assign tail_id  = gnt_idx;
        end
    endgenerate

    // ID/result only change when a valid result lands, so they stay stable while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
        end else if (adv) begin
            resp_valid <= tail_vld;
            if (tail_vld) begin
                resp_id     <= tail_id;
                resp_result <= mm_result;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (run && (tail_vld != mm_valid_out))
            err <= 1'b1;
    end

`ifdef MAT_MUL_SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops   <= '0;
            perf_stall <= '0;
            perf_idle  <= '0;
        end else begin
            if (resp_valid && resp_ready)
                perf_ops <= perf_ops + 1'b1;
            if (run && !adv)
                perf_stall <= perf_stall + 1'b1;
            if (run && adv && !grant_vld)
                perf_idle <= perf_idle + 1'b1;
        end
    end
`endif

endmodule

// File: doc/mat_mul_sched.md
# mat_mul_sched

Shares one `mat_mul` datapath among `NUM_REQ` requesters with round-robin arbitration. Tracks each issued operation's requester ID through the datapath's summation pipeline. Returns results on a single valid/ready response channel, stalling the datapath through `cen` under back-pressure. It sits between the SIMD lane request ports and the `mat_mul` instance, and drives every `mat_mul` control and data input.

## Interface
- `W_IN`, 8, element width of the input matrices
- `W_OUT`, 32, element width of the result
- `N`, 2, matrix dimension (N×N); power of two, ≥1
- `NUM_REQ`, 4, number of requesters, ≥2
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in `NUM_REQ`: per-requester operation request.
- `req_ready` out `NUM_REQ`: per-requester grant, one-hot or zero.
- `req_matrix_1`, `req_matrix_2` in `NUM_REQ`×N×N×`W_IN`: signed operands, one set per requester.
- `resp_valid` out 1, `resp_ready` in 1: result handshake.
- `resp_id` out `ID_W`: index of the requester that issued the result.
- `resp_result` out N×N×`W_OUT`: signed product.
- `mm_cen`, `mm_valid_in` out 1; `mm_matrix_1`, `mm_matrix_2` out N×N×`W_IN`: datapath drive.
- `mm_valid_out` in 1, `mm_result` in N×N×`W_OUT`: datapath return.
- `err` out 1: sticky valid-mismatch flag.

## Operation
- `LAT = $clog2(N)` is the datapath register depth. `ID_W = max(1, $clog2(NUM_REQ))`.
- FSM states:
  - FLUSH, entered on reset: `mm_cen=1`, `mm_valid_in=0`, `req_ready=0`. A counter runs `LAT` cycles, then the FSM moves to RUN. When `LAT=0` the FSM goes straight to RUN. This clears the unreset valid stages inside `mat_mul`.
  - RUN, steady state.
- Advance condition: `adv = !resp_valid || resp_ready`. `mm_cen = adv` in RUN.
- Grant:
  - When `adv` is high in RUN, the requester with `req_valid` high is picked, searching round-robin starting at `last+1` mod `NUM_REQ`.
  - The chosen requester gets `req_ready` high, its operands are muxed onto `mm_matrix_*`, `mm_valid_in=1`, and `last` is updated.
  - If no request is pending, `mm_valid_in=0` and the operand buses are driven to 0.
- Requester rules: `req_ready` may depend on `req_valid`. A requester holds `req_valid` and its operands stable until it sees `req_ready`.
- Tracking pipeline: an internal valid/ID shift register of `LAT` stages, resettable, shifts on `adv`. Stage 0 is loaded with the grant.
- Response register:
  - Loads on `adv` with `{tail valid, tail ID, mm_result}`.
  - When `LAT=0`, "tail" is the current grant.
  - `resp_valid` clears on handshake when nothing new is loaded.
- Check: in RUN, tail valid ≠ `mm_valid_out` sets `err`, which stays set until reset.
- Reset mid-operation: in-flight operations are discarded. No response is produced for them, and requesters must re-request.

## Timing
- Reset values: `req_ready=0`, `resp_valid=0`, `resp_id=0`, `resp_result=0`, `mm_valid_in=0`, `mm_cen=1`, `err=0`, `last=NUM_REQ-1` (so requester 0 wins first).
- Latency: a grant in cycle t gives `resp_valid` in cycle t+`LAT`+1 when there is no back-pressure.
- Throughput: one operation per cycle.
- Stall behaviour:
  - While `resp_valid && !resp_ready`, every stage holds and no grant is issued.
  - The response holds stable.
  - The cycle after `resp_ready` returns, the pipeline resumes with no loss or duplication.
- Simultaneous handshake and load: the response register takes the new value in the same edge; results stay back-to-back.

## Configuration
- `MAT_MUL_SCHED_PERF_EN` defined: adds outputs `perf_ops` (32 b, completed response handshakes), `perf_stall` (32 b, RUN cycles with `!adv`) and `perf_idle` (32 b, RUN cycles with `adv` and no grant). These counters reset to 0 and wrap silently.
- Undefined: these ports and their counters do not exist.

## Structure
- `mat_mul_pkg` holds:
  - the `lat_f(N)` function;
  - `id_w_f(NUM_REQ)`;
  - the FSM state enum `{FLUSH, RUN}`.
- `mat_mul_sched` contains the FSM, operand mux, tracking pipeline, response register and perf counters.
- Sub-module `rr_arbiter` has parameter `NUM_REQ`. Inputs: `clk`, `rst`, `req`, `en`. Outputs: one-hot `gnt` and `gnt_idx`. It holds the pointer and updates it only when `en` is high and a grant is issued.

## Test plan
- Single request, N=2, requester 0. Operands `[[1,2],[3,4]]` × `[[5,6],[7,8]]`, granted in cycle t → `resp_valid` at t+2 with `[[19,22],[43,50]]` and `resp_id=0`.
- Signed operands on requester 2: `[[-1,0],[0,-1]]` × `[[127,-128],[3,4]]` → `[[-127,128],[-3,-4]]` with `resp_id=2`.
- All four requesters held valid continuously with `resp_ready=1` → grant order 0,1,2,3,0,…, one response per cycle, IDs in the same order.
- `resp_ready` low for 5 cycles while three operations are in flight → response held unchanged, no `req_ready`, `mm_cen=0`. After release, the three results arrive on consecutive cycles in order.
- `rst` asserted while two operations are in flight → immediately `resp_valid=0` and `req_ready=0`. After release there is one FLUSH cycle (`mm_valid_in=0`), and no stale response ever appears.
- `err` stays 0 in every scenario above. Forcing `mm_valid_out=1` during an idle cycle in RUN → `err=1`, held until reset.
